// File: rtl/snake_direction_ctrl.sv
// Button conditioner for the snake game: synchronize, debounce, turn presses into
// one-hot direction requests and commit one per snake step. Optional: SNAKE_DIR_QUEUE2_EN.
module snake_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1064700
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Buttons,
  input  logic       i_SnakeStep,
  input  logic       i_GameOver,
  output logic [3:0] o_Direction,
  output logic       o_Pending,
  output logic       o_Start
);

  localparam int                  CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       sync1, sync2, deb, deb_d;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       press, cand, dir_q, head, ref_dir;
  logic             cand_valid, start_q, pending, run_live, pop, room, accept, clear_buf;

  // Synchronizer and debouncer: all four buttons share one process.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!i_Rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int b = 0; b < 4; b++) cnt[b] <= '0;
    end else begin
      sync1 <= i_Buttons;
      sync2 <= sync1;
      deb_d <= deb;
      for (int b = 0; b < 4; b++) begin
        if (sync2[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          deb[b] <= sync2[b];
          cnt[b] <= '0;
        end else if (cnt[b] != CNT_MAX) begin
          cnt[b] <= cnt[b] + CNT_ONE;
        end
      end
    end
  end

  assign press      = deb & ~deb_d;
  assign cand_valid = |press;

  // Simultaneous presses collapse to one candidate: up > down > left > right.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    cand = '0;
    if      (press[0]) cand = 4'b0001;
    else if (press[1]) cand = 4'b0010;
    else if (press[2]) cand = 4'b0100;
    else if (press[3]) cand = 4'b1000;
  end

  assign run_live  = (state_q == S_RUN) && !i_GameOver;
  assign clear_buf = (state_q != S_RUN) || i_GameOver;
  assign pop       = run_live && i_SnakeStep && pending;
  assign accept    = run_live && cand_valid && (cand != ref_dir) &&
                     (cand != opposite(ref_dir)) && room;

`ifdef SNAKE_DIR_QUEUE2_EN
  logic [3:0] q0, q1, q0_n, q1_n;
  logic [1:0] q_cnt, q_cnt_n;

  assign pending = (q_cnt != 2'd0);
  assign head    = q0;
  assign room    = (q_cnt != 2'd2) || pop;

  // The request is checked against whatever will be last in line after this edge.
  always_comb begin
    ref_dir = dir_q;
    if      (q_cnt == 2'd2) ref_dir = q1;
    else if (q_cnt == 2'd1) ref_dir = q0;
  end

  always_comb begin
    q0_n    = q0;
    q1_n    = q1;
    q_cnt_n = q_cnt;
    if (pop) begin
      q0_n    = q1;
      q1_n    = '0;
      q_cnt_n = q_cnt - 2'd1;
    end
    if (accept) begin
      if (q_cnt_n == 2'd0) q0_n = cand;
      else                 q1_n = cand;
      q_cnt_n = q_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst || clear_buf) begin
      q0    <= '0;
      q1    <= '0;
      q_cnt <= '0;
    end else begin
      q0    <= q0_n;
      q1    <= q1_n;
      q_cnt <= q_cnt_n;
    end
  end
`else
  logic [3:0] pend_dir;
  logic       pend_valid;

  assign pending = pend_valid;
  assign head    = pend_dir;
  assign room    = 1'b1;
  assign ref_dir = pop ? pend_dir : dir_q;

  // Last accepted request wins over an uncommitted one.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst || clear_buf) begin
      pend_dir   <= '0;
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_dir   <= cand;
      pend_valid <= 1'b1;
    end else if (pop) begin
      pend_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      dir_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (state_q == S_IDLE && cand_valid) begin
        dir_q   <= cand;
        start_q <= 1'b1;
      end else if (pop) begin
        dir_q <= head;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cand_valid) state_d = S_RUN;
      S_RUN:   if (i_GameOver) state_d = S_DEAD;
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Direction = dir_q;
    o_Pending   = pending;
    o_Start     = start_q;
  end

endmodule

// File: doc/snake_direction_ctrl.md
# snake_direction_ctrl

Input conditioner between the Basys3 direction buttons and the snake game logic. It synchronizes and debounces four raw buttons and turns presses into a one-hot direction. It rejects 180° reversals and no-op presses, and buffers the accepted request until the next snake step strobe, so the game sees exactly one direction change per move. It also produces the game-start pulse.

## Interface
- DEBOUNCE_CYCLES, 1064700: consecutive cycles a synchronized level must persist before it is accepted (≈10 ms at 106.47 MHz); minimum 2.
- i_Clk  in  1  system clock; sole clock of the block.
- i_Rst  in  1  synchronous, active-low reset.
- i_Buttons  in  4  raw buttons, asynchronous; bit0 up, bit1 down, bit2 left, bit3 right; 1 = pressed.
- i_SnakeStep  in  1  single-cycle strobe, synchronous to i_Clk, marking a snake move.
- i_GameOver  in  1  level from game logic; high = snake dead.
- o_Direction  out  4  committed one-hot direction (same bit order); 0000 before game start.
- o_Pending  out  1  at least one accepted request is awaiting commit.
- o_Start  out  1  one-cycle pulse when the first direction is committed.

## Operation
- Per button: 2-flop synchronizer → debouncer. Debounced state flips on the edge at which the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive edges. Any cycle of agreement clears the counter. Counter width is $clog2(DEBOUNCE_CYCLES+1) and it saturates, never wraps.
- A press event is a debounced 0→1 edge. Releases generate nothing.
- Multiple press events on the same cycle: one candidate, with priority up > down > left > right. The others are discarded.
- Reference direction R = the direction that will be committed after the current edge. R is the pending head if i_SnakeStep and o_Pending are high this cycle, otherwise o_Direction. With SNAKE_DIR_QUEUE2_EN and an entry remaining after the pop, R is the last queued entry.
- A candidate is accepted only if it is neither equal nor opposite to R (up/down and left/right are opposites).
- State machine:
  - IDLE (reset state): the first candidate is committed directly to o_Direction with no reversal check and without waiting for a step. o_Start pulses and the state goes to RUN.
  - RUN: accepted candidates go to the pending buffer. On i_SnakeStep with o_Pending high, the head moves into o_Direction. A step with nothing pending leaves o_Direction unchanged. i_GameOver high moves the state to DEAD.
  - DEAD: press events and steps are ignored, and the pending buffer is cleared. o_Direction holds. Only reset exits DEAD.
- A step and an accepted press on the same edge: the commit happens and the new request lands in the buffer, checked against R as defined above.
- i_GameOver and a step on the same edge in RUN: GameOver wins and there is no commit.

## Timing
- Reset values: o_Direction 0000, o_Pending 0, o_Start 0, state IDLE, debounced states 0, counters 0, synchronizers 0.
- Reset mid-debounce or with a request pending discards everything; the next press restarts the full debounce.
- Latency from the first sampling edge of a stable i_Buttons change:
  - 2 edges of synchronizer, then DEBOUNCE_CYCLES edges to flip the debounced state, then 1 edge to update o_Direction (IDLE) or the pending buffer (RUN).
  - Total is DEBOUNCE_CYCLES+3 edges.
- o_Start is high for exactly the cycle in which o_Direction first becomes nonzero.
- Commit latency is 1 edge: the edge sampling i_SnakeStep=1 updates o_Direction.
- o_Pending drops on that same edge unless a new request is written on that edge or a queued entry remains.

## Configuration
- SNAKE_DIR_QUEUE2_EN defined: the pending buffer is a 2-entry FIFO, committed one entry per step.
  - The second request is checked against the first queued entry.
  - A request arriving when the FIFO is full is dropped; a step on the same edge frees a slot and the request is accepted.
- SNAKE_DIR_QUEUE2_EN undefined: single pending register. A newly accepted request overwrites any uncommitted one (last wins), checked against o_Direction.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, assert up continuously → o_Direction=0001 and o_Start=1 for one cycle, 7 edges after the first sampled high. o_Pending stays 0.
- Start up; toggle left every 2 cycles for 20 cycles, then release → no press event, o_Direction=0001, o_Pending=0.
- Start up; press down, then step → o_Pending never asserts; o_Direction stays 0001.
- Start up; press left, release, press right (no step between) → o_Pending=1.
  - Without the macro, the next step gives 1000 (right).
  - With the macro, right is rejected against left and the step gives 0100 (left).
- Start up, left pending; down's press event coincides with i_SnakeStep → o_Direction=0100 that edge, o_Pending stays 1; next step → 0010.
- Start up, left pending; assert i_GameOver then step → o_Direction holds 0001 and o_Pending=0; later presses ignored. Assert i_Rst=0 for one cycle → all outputs 0, state IDLE.
